// File: rtl/led_fader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_fader_pkg
// Description : Shared constants for the LED fader: register indices on
//               address bits [3:2], register reset values, and a byte-lane
//               merge helper used by the bus write path.
// Revision    : 1.0 - initial release
// ============================================================================
package led_fader_pkg;

   // Register indices (address_in[3:2])
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PEAK   = 2'd1;
   localparam logic [1:0] REG_PERIOD = 2'd2;
   localparam logic [1:0] REG_STEP   = 2'd3;

   // Reset values (CTRL: bit0 enable, bit1 invert)
   localparam logic [1:0]  CTRL_RESET   = 2'b01;
   localparam logic [31:0] PEAK_RESET   = 32'h0000_00FF;
   localparam logic [31:0] PERIOD_RESET = 32'd1000;
   localparam logic [31:0] STEP_RESET   = 32'h0000_0010;

   // Replace each byte of cur whose mask bit is set with the matching byte
   // of wdata; narrower registers simply discard the upper result bytes.
   function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  mask);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

endpackage : led_fader_pkg
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
// Module      : led_channel
// Description : One LED channel. Holds the intensity register, reloads it
//               to PEAK while the scanner bit is on, decays it by STEP
//               (saturating at 0) on each decay tick, and produces the
//               registered PWM output.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               load              - scanner bit for this channel
//               tick              - one-cycle decay strobe
//               peak, step        - load value and decay amount
//               pwm_cnt           - shared free-running PWM counter
//               enable, invert    - output control
//               led               - registered PWM output
// Revision    : 1.0 - initial release
// ============================================================================
module led_channel #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                tick,
   input  logic [PWM_BITS-1:0] peak,
   input  logic [PWM_BITS-1:0] step,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                enable,
   input  logic                invert,
   output logic                led
);

   logic [PWM_BITS-1:0] r_intensity;
   logic [PWM_BITS-1:0] w_decayed;

   // Saturating subtract: never wraps below zero.
   assign w_decayed = (r_intensity > step) ? (r_intensity - step) : '0;

   // Load has priority over a coincident decay tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_intensity <= '0;
      end else if (load) begin
         r_intensity <= peak;
      end else if (tick) begin
         r_intensity <= w_decayed;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led <= 1'b0;
      end else begin
         led <= enable & ((r_intensity > pwm_cnt) ^ invert);
      end
   end

endmodule : led_channel
`default_nettype wire

// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
// Module      : led_fader
// Description : PWM fader for the KITT scanner LEDs. Each lit scanner bit
//               loads its channel to PEAK; unlit channels decay by STEP
//               every PERIOD+1 cycles. Configuration is via a zero-wait-state
//               32-bit register bus.
// Ports       : clk, reset                      - clock, sync active-high reset
//               pattern_in                      - scanner on/off pattern
//               led_out                         - PWM LED outputs
//               address_in, sel_in, write_mask_in, write_value_in,
//               read_value_out, ready_out       - register bus
// Revision    : 1.0 - initial release
// ============================================================================
module led_fader
   import led_fader_pkg::*;
#(
   parameter int NLEDS    = 5,
   parameter int PWM_BITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NLEDS-1:0] pattern_in,
   output logic [NLEDS-1:0] led_out,
   input  logic [31:0]      address_in,
   input  logic             sel_in,
   output logic [31:0]      read_value_out,
   input  logic [3:0]       write_mask_in,
   input  logic [31:0]      write_value_in,
   output logic             ready_out
);

   logic [1:0]          r_ctrl;
   logic [PWM_BITS-1:0] r_peak;
   logic [31:0]         r_period;
   logic [PWM_BITS-1:0] r_step;
   logic [31:0]         r_decay_cnt;
   logic [PWM_BITS-1:0] r_pwm_cnt;

   logic [1:0]  w_reg;
   logic        w_wr;
   logic [31:0] w_cur;
   logic [31:0] w_merged;
   logic        w_tick;
   logic        w_unused_addr;

   assign w_reg         = address_in[3:2];
   assign w_wr          = sel_in & (|write_mask_in);
   assign w_unused_addr = ^{address_in[31:4], address_in[1:0]};
   assign ready_out     = sel_in;

   // Selected register, zero-extended; shared by read-back and write merge.
   always_comb begin
      w_cur = '0;
      case (w_reg)
         REG_CTRL:   w_cur = {30'b0, r_ctrl};
         REG_PEAK:   w_cur = 32'(r_peak);
         REG_PERIOD: w_cur = r_period;
         REG_STEP:   w_cur = 32'(r_step);
         default:    w_cur = '0;
      endcase
   end

   assign w_merged       = byte_merge(w_cur, write_value_in, write_mask_in);
   assign read_value_out = sel_in ? w_cur : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl   <= CTRL_RESET;
         r_peak   <= PEAK_RESET[PWM_BITS-1:0];
         r_period <= PERIOD_RESET;
         r_step   <= STEP_RESET[PWM_BITS-1:0];
      end else if (w_wr) begin
         case (w_reg)
            REG_CTRL:   r_ctrl   <= w_merged[1:0];
            REG_PEAK:   r_peak   <= w_merged[PWM_BITS-1:0];
            REG_PERIOD: r_period <= w_merged;
            REG_STEP:   r_step   <= w_merged[PWM_BITS-1:0];
            default:    r_ctrl   <= r_ctrl;
         endcase
      end
   end

   // Decay timer: ticks when the count reaches PERIOD, so PERIOD=0 ticks
   // every cycle. A PERIOD write restarts the count.
   assign w_tick = (r_decay_cnt == r_period);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_decay_cnt <= '0;
      end else if (w_wr && (w_reg == REG_PERIOD)) begin
         r_decay_cnt <= '0;
      end else if (w_tick) begin
         r_decay_cnt <= '0;
      end else begin
         r_decay_cnt <= r_decay_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NLEDS; i++) begin : g_chan
      led_channel #(
         .PWM_BITS (PWM_BITS)
      ) u_chan (
         .clk     (clk),
         .reset   (reset),
         .load    (pattern_in[i]),
         .tick    (w_tick),
         .peak    (r_peak),
         .step    (r_step),
         .pwm_cnt (r_pwm_cnt),
         .enable  (r_ctrl[0]),
         .invert  (r_ctrl[1]),
         .led     (led_out[i])
      );
   end

endmodule : led_fader
`default_nettype wire

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter: NLEDS, 5, number of LED channels (matches the 5-bit scanner pattern).
REQ-002 Parameter: PWM_BITS, 8, width of the intensity and PWM counter.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: pattern_in  input  NLEDS  on/off pattern from the upstream KITT scanner (display_out).
REQ-006 Port: led_out  output  NLEDS  PWM-driven LED pins.
REQ-007 Port: address_in  input  32  bus address; bits [3:2] select the register.
REQ-008 Port: sel_in  input  1  bus select for this peripheral.
REQ-009 Port: read_value_out  output  32  read data for the selected register.
REQ-010 Port: write_mask_in  input  4  byte-write enables.
REQ-011 Port: write_value_in  input  32  write data.
REQ-012 Port: ready_out  output  1  bus acknowledge.

Function
REQ-013 ready_out SHALL equal sel_in combinationally, giving a zero-wait-state bus.
REQ-014 Register map (address_in[3:2]) SHALL be:
- 0 = CTRL: bit0 enable, bit1 invert.
- 1 = PEAK: [PWM_BITS-1:0].
- 2 = PERIOD: [31:0].
- 3 = STEP: [PWM_BITS-1:0].
- Unused bits SHALL read 0.
REQ-015 When sel_in=1, write_mask_in[i] SHALL write write_value_in[8i+7:8i] into byte i of the selected register; bytes beyond the register width SHALL be ignored.
REQ-016 read_value_out SHALL be combinational, returning the selected register when sel_in=1, else 0.
REQ-017 Decay timer: a 32-bit counter SHALL increment each cycle.
- When the counter equals PERIOD, a one-cycle decay_tick SHALL fire and the counter SHALL return to 0.
- PERIOD=0 SHALL tick every cycle.
REQ-018 Any write to PERIOD SHALL clear the decay counter in the same clock edge.
REQ-019 Per channel i, if pattern_in[i]=1, intensity[i] SHALL load PEAK next cycle, taking priority over a coincident decay_tick.
REQ-020 Per channel i, if pattern_in[i]=0 and decay_tick=1, intensity[i] SHALL become intensity[i]-STEP, saturating at 0 (no wrap-around).
REQ-021 A PWM_BITS-bit counter SHALL free-run from 0 to 2^PWM_BITS-1 and wrap to 0.
REQ-022 Registered output: led_out[i] SHALL be (intensity[i] > pwm_cnt) XOR invert when enable=1, and 0 when enable=0.
- Latency is 1 cycle from intensity/pwm_cnt to led_out.
REQ-023 enable=0 SHALL NOT stop the intensity, decay or PWM logic.
REQ-024 A PEAK write SHALL affect only subsequent loads, not intensities already held.
REQ-025 intensity=0 SHALL give led_out constantly low (non-inverted); intensity=2^PWM_BITS-1 SHALL give high for 255 of 256 PWM cycles.

Reset
REQ-026 On reset the block SHALL set:
- CTRL=0x1, PEAK=0xFF, PERIOD=1000, STEP=0x10.
- All intensities=0, pwm_cnt=0, decay counter=0.
- led_out=0.
REQ-027 Reset asserted mid-operation SHALL override bus writes and pattern loads in that cycle.

Structure
REQ-028 Package led_fader_pkg SHALL hold the register index constants (REG_CTRL, REG_PEAK, REG_PERIOD, REG_STEP) and the reset-value constants.
REQ-029 One sub-module, led_channel, SHALL implement a single channel's intensity register, saturating decay and PWM compare, instantiated NLEDS times.
REQ-030 The top level SHALL hold the bus registers, decay timer and PWM counter.

Verification
REQ-031 Reset, then read all four registers -> 0x1, 0xFF, 1000, 0x10; led_out=0.
REQ-032 Write PERIOD=3 with mask 0xF; hold pattern_in=5'b00001 for 1 cycle, then 0 -> intensity[0]=0xFF, then 0xEF, 0xDF ... every 4 cycles, reaching 0 and staying 0.
REQ-033 STEP=0x30, PEAK=0x20, pulse pattern bit -> intensity 0x20 -> 0x00 on the first tick (saturation, no wrap to 0xF0).
REQ-034 PERIOD=0 and pattern_in[2] held 1 -> intensity[2] stays 0xFF despite a tick every cycle (load priority).
REQ-035 PEAK=0x40, pattern held on, enable=1 -> led_out high for exactly 64 of each 256 cycles; set invert=1 -> 192 of 256; enable=0 -> constant 0.
REQ-036 Byte-lane write of 0xAABBCCDD to PERIOD with mask 4'b0010 -> PERIOD=0x0000CC00 (after clearing), decay counter cleared; ready_out tracks sel_in every cycle.
